// File: rtl/hu_pkg.sv
// Shared definitions for the pipelined-CPU hazard unit: forwarding mux
// encodings and the default register-address width.
package hu_pkg;

  localparam int HU_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hu_md_tracker.sv
// Busy tracker for the multi-cycle mul/div unit. A down-counter is loaded
// with the unit latency on issue and counts down to zero; HI/LO are valid
// once it reaches zero. Issue is ignored while the pipeline is frozen, but
// the counter keeps running because the mul/div unit itself never stops.
module hu_md_tracker
  import hu_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  output logic busy
);

  localparam int CW = $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count;

  // Load on a real issue, otherwise count down towards zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (start && !hold) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hu_mc.sv
// Hazard unit for the 5-stage pipeline: EX and ID forwarding, load-use,
// branch and mul/div interlocks, a whole-pipeline freeze while the data
// memory is not ready, and a saturating stall-cycle counter for debug.
module hu_mc
  import hu_pkg::*;
#(
  parameter int REG_AW     = HU_REG_AW,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              cu_branch_id,
  input  logic              md_use_id,
  input  logic [REG_AW-1:0] rs_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] write_reg_ex,
  input  logic              cu_reg_write_ex,
  input  logic              cu_mem_to_reg_ex,
  input  logic              md_start_ex,
  input  logic [REG_AW-1:0] write_reg_mem,
  input  logic              cu_reg_write_mem,
  input  logic              cu_mem_to_reg_mem,
  input  logic              mem_req_mem,
  input  logic              mem_ready,
  input  logic [REG_AW-1:0] write_reg_wb,
  input  logic              cu_reg_write_wb,
  input  logic              stat_clr,
  output logic [1:0]        forward_a_ex,
  output logic [1:0]        forward_b_ex,
  output logic              forward_a_id,
  output logic              forward_b_id,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_ex,
  output logic              flush_wb,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cycles
);

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;
  logic     id_hits_ex;
  logic     id_hits_mem;
  logic     lw_stall;
  logic     branch_stall;
  logic     md_stall;
  logic     mem_stall;
  logic     soft_stall;

  // EX operand forwarding: the newer MEM result wins over WB; $0 never forwards.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rs_ex != '0 && cu_reg_write_mem && rs_ex == write_reg_mem) begin
      fwd_a = FWD_MEM;
    end else if (rs_ex != '0 && cu_reg_write_wb && rs_ex == write_reg_wb) begin
      fwd_a = FWD_WB;
    end
    if (rt_ex != '0 && cu_reg_write_mem && rt_ex == write_reg_mem) begin
      fwd_b = FWD_MEM;
    end else if (rt_ex != '0 && cu_reg_write_wb && rt_ex == write_reg_wb) begin
      fwd_b = FWD_WB;
    end
  end

  assign forward_a_ex = fwd_a;
  assign forward_b_ex = fwd_b;

  // The branch comparator in ID can only take an ALU result from MEM, not load data.
  assign forward_a_id = (rs_id != '0) && (rs_id == write_reg_mem) &&
                        cu_reg_write_mem && !cu_mem_to_reg_mem;
  assign forward_b_id = (rt_id != '0) && (rt_id == write_reg_mem) &&
                        cu_reg_write_mem && !cu_mem_to_reg_mem;

  assign id_hits_ex  = (write_reg_ex != '0) &&
                       (write_reg_ex == rs_id || write_reg_ex == rt_id);
  assign id_hits_mem = (write_reg_mem != '0) &&
                       (write_reg_mem == rs_id || write_reg_mem == rt_id);

  assign lw_stall     = cu_mem_to_reg_ex && id_hits_ex;
  assign branch_stall = cu_branch_id &&
                        ((cu_reg_write_ex && id_hits_ex) ||
                         (cu_mem_to_reg_mem && id_hits_mem));
  assign md_stall     = md_use_id && (md_busy || md_start_ex);
  assign mem_stall    = mem_req_mem && !mem_ready;
  assign soft_stall   = lw_stall || branch_stall || md_stall;

  hu_md_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_tracker (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_ex),
    .hold  (mem_stall),
    .busy  (md_busy)
  );

  // A memory freeze holds every stage and bubbles WB; other hazards stall the front end only.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    if (mem_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (soft_stall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // Saturating count of front-end stall cycles; a clear request wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stat_clr) begin
      stall_cycles <= '0;
    end else if (stall_if && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: doc/hu_mc.md
Name: hu_mc

Overview:
Hazard unit for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB). It is the parametrised successor of the single-cycle hazard unit: register-address width is generic, and it corrects load-use detection to ignore $0 and require a real write. It adds two sequential features: a busy tracker for a multi-cycle mul/div unit (HI/LO interlock) and a whole-pipeline freeze for a variable-latency data memory (mem_ready handshake). A saturating stall-cycle counter supports performance debug.

Parameters:
REG_AW, 5, register address width; register 0 is hard-wired zero
MD_LATENCY, 4, mul/div cycles after issue before HI/LO are valid (>=1)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rs_id, rt_id  in  REG_AW  source regs of instruction in ID
cu_branch_id  in  1  ID instruction is a branch compared in ID
md_use_id  in  1  ID instruction reads HI/LO or issues mul/div
rs_ex, rt_ex  in  REG_AW  source regs in EX
write_reg_ex  in  REG_AW  dest reg in EX
cu_reg_write_ex  in  1  EX writes register file
cu_mem_to_reg_ex  in  1  EX is a load
md_start_ex  in  1  EX instruction issues mul/div
write_reg_mem  in  REG_AW  dest reg in MEM
cu_reg_write_mem  in  1  MEM writes register file
cu_mem_to_reg_mem  in  1  MEM is a load
mem_req_mem  in  1  MEM stage accesses data memory
mem_ready  in  1  data memory completes access this cycle
write_reg_wb  in  REG_AW  dest reg in WB
cu_reg_write_wb  in  1  WB writes register file
stat_clr  in  1  synchronous clear of stall_cycles
forward_a_ex, forward_b_ex  out  2  EX operand mux: 00 regfile, 01 WB result, 10 MEM alu result
forward_a_id, forward_b_id  out  1  ID branch comparator takes MEM alu result
stall_if, stall_id, stall_ex, stall_mem  out  1  hold pipeline register of that stage
flush_ex  out  1  insert bubble into EX
flush_wb  out  1  insert bubble into WB
md_busy  out  1  mul/div result not yet valid
stall_cycles  out  CNT_W  saturating count of cycles with stall_if high

Behaviour:
- Reset: md counter=0, md_busy=0, stall_cycles=0. All other outputs are combinational from inputs. Reset mid-mul/div clears the counter at once.
- EX forwarding, per operand (rs_ex->a, rt_ex->b): if reg!=0 and matches write_reg_mem with cu_reg_write_mem -> 10. Else if it matches write_reg_wb with cu_reg_write_wb -> 01. Else 00. MEM has priority over WB.
- ID forwarding: forward_a_id = rs_id!=0 & rs_id==write_reg_mem & cu_reg_write_mem & ~cu_mem_to_reg_mem. Same for rt.
- lw_stall = cu_mem_to_reg_ex & write_reg_ex!=0 & (write_reg_ex==rs_id | write_reg_ex==rt_id).
- branch_stall = cu_branch_id & [ (cu_reg_write_ex & write_reg_ex!=0 & match rs_id/rt_id) | (cu_mem_to_reg_mem & write_reg_mem!=0 & match rs_id/rt_id) ].
- md tracker:
  - Counter loads MD_LATENCY when md_start_ex & ~mem_stall.
  - Otherwise it decrements by 1 when nonzero.
  - md_busy = counter!=0.
  - md_stall = md_use_id & (md_busy | md_start_ex).
  - MD_LATENCY=4, issue in EX at cycle t: counter 4,3,2,1 on t+1..t+4; a dependent instruction leaves ID at t+5.
- mem_stall = mem_req_mem & ~mem_ready.
  - Freezes everything: stall_if=stall_id=stall_ex=stall_mem=1, flush_wb=1, flush_ex=0.
  - It has priority over every other stall.
  - The counter keeps decrementing during a freeze. A held md_start_ex does not reload it.
- Otherwise, if lw_stall | branch_stall | md_stall: stall_if=stall_id=flush_ex=1, with stall_ex=stall_mem=flush_wb=0.
- If no stall condition holds, all stall/flush outputs are 0.
- stall_cycles:
  - stat_clr has priority and clears to 0.
  - Otherwise it increments on each cycle with stall_if=1.
  - It saturates at all-ones.

Decomposition:
- Shared package hu_pkg holds the forward encodings FWD_RF=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10, plus the default REG_AW.
- One sub-module, hu_md_tracker (params MD_LATENCY), with inputs clk, rst, start, hold and output busy. It owns the down-counter, width $clog2(MD_LATENCY+1).

Test Plan:
- rs_ex=3, write_reg_mem=3, write_reg_wb=3, both reg_write=1 -> forward_a_ex=10. Repeat with rs_ex=0 -> 00.
- Load in EX writes r5, ID reads rt_id=5 -> stall_if=stall_id=flush_ex=1 for 1 cycle. Same case with write_reg_ex=0 -> no stall.
- Branch in ID with rs_id=7; ALU op in EX writes r7 -> 1-cycle stall, then forward_a_id=1 next cycle. If instead a load is in MEM writing r7 -> stall and forward_a_id=0.
- md_start_ex at t with MD_LATENCY=4, md_use_id held -> stall_if high t..t+4 and low at t+5; md_busy high t+1..t+4.
- mem_req_mem=1, mem_ready=0 for 3 cycles during an md op -> all four stalls and flush_wb high for 3 cycles, flush_ex=0. Counter still reaches 0 on schedule. stall_cycles advances by 3.
- CNT_W=2, stall held 5 cycles -> stall_cycles saturates at 3. Then stat_clr -> 0. Async rst mid-md -> md_busy=0 without waiting for a clock edge.
